// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and latency helpers for the 512-point
// radix-2 single-delay-feedback FFT control path.
//   LOG2N/N    : FFT size exponent and size (stage count L == LOG2N)
//   STAGE_LAT  : register latency of one stage, excluding its delay line
//   stage_offset(s) : stream latency D_s from the input to stage s
//   TOTAL_LAT  : latency from the input to the pipeline output (520)
package fft_pkg;

  localparam int LOG2N     = 9;
  localparam int N         = 1 << LOG2N;
  localparam int L         = LOG2N;
  localparam int STAGE_LAT = 1;
  localparam int TW_W      = L - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Each earlier stage k adds its delay line 2**(L-1-k) plus its register latency.
  function automatic int stage_offset(input int s);
    int d;
    d = 0;
    for (int k = 0; k < s; k++) begin
      d += (1 << (L - 1 - k)) + STAGE_LAT;
    end
    return d;
  endfunction

  localparam int TOTAL_LAT = stage_offset(L);
  localparam int F_W       = $clog2(TOTAL_LAT + 1);

endpackage

// File: rtl/fft_stage_ctl.sv
// Combinational decode of the shared stream position into one stage's
// controls. The top registers the results.
//   p       : phase counter P (pre-increment)
//   f       : fill counter F (pre-increment, saturating)
//   bf_en   : 1 = butterfly phase, 0 = delay-line fill/pass
//   tw_en   : twiddle multiply applied to this stage's output
//   tw_addr : twiddle ROM address
module fft_stage_ctl
  import fft_pkg::*;
#(
  parameter int STAGE = 0
) (
  input  logic [LOG2N-1:0] p,
  input  logic [F_W-1:0]   f,
  output logic             bf_en,
  output logic             tw_en,
  output logic [TW_W-1:0]  tw_addr
);

  localparam int                D        = stage_offset(STAGE);
  localparam int                HALF     = 1 << (L - 1 - STAGE);
  localparam logic [LOG2N-1:0]  D_MOD    = LOG2N'(D % N);
  localparam logic [LOG2N-1:0]  LOW_MASK = LOG2N'(HALF - 1);
  localparam logic [F_W-1:0]    TW_FILL  = F_W'(D + HALF);

  logic [LOG2N-1:0] idx;
  logic             stage_vld;

  // Position of the sample currently at this stage's input.
  assign idx = p - D_MOD;

  if (D == 0) begin : g_first
    assign stage_vld = 1'b1;
  end else begin : g_later
    localparam logic [F_W-1:0] D_F = F_W'(D);
    assign stage_vld = (f >= D_F);
  end

  assign bf_en = stage_vld & idx[L-1-STAGE];
  // The twiddle only applies once the delay line has held a full half-block.
  assign tw_en = stage_vld & ~idx[L-1-STAGE] & (f >= TW_FILL);
  // Last stage: LOW_MASK is 0, so the address is always W^0.
  assign tw_addr = TW_W'((idx & LOW_MASK) << STAGE);

endmodule

// File: rtl/fft512_sdf_sequencer.sv
// Central control sequencer for the 512-point radix-2 SDF FFT pipeline.
// Holds the FSM, phase counter P, fill counter F and drain counter, and
// registers the per-stage controls and the output-frame markers.
//   in_valid/in_ready : input handshake (in_ready low only while draining)
//   flush             : pulse, drain the pipeline after the last sample
//   busy              : sequencer not idle
//   bf_en/tw_en       : per-stage butterfly select / twiddle enable
//   tw_addr           : per-stage twiddle address, slice [s*(L-1)+:L-1]
//   out_valid/out_idx/out_last : output sample marker, index, frame end
module fft512_sdf_sequencer
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic                busy,
  output logic [L-1:0]        bf_en,
  output logic [L-1:0]        tw_en,
  output logic [L*TW_W-1:0]   tw_addr,
  output logic                out_valid,
  output logic [LOG2N-1:0]    out_idx,
  output logic                out_last
);

  localparam logic [F_W-1:0]   F_SAT     = F_W'(TOTAL_LAT);
  localparam logic [F_W-1:0]   DRAIN_END = F_W'(TOTAL_LAT - 1);
  localparam logic [LOG2N-1:0] TL_MOD    = LOG2N'(TOTAL_LAT % N);
  localparam logic [LOG2N-1:0] IDX_LAST  = LOG2N'(N - 1);

  state_t           state, state_next;
  logic [LOG2N-1:0] p;
  logic [F_W-1:0]   f;
  logic [F_W-1:0]   drain;
  logic             advance;
  logic             drain_done;

  logic [L-1:0]      bf_next, tw_next;
  logic [L*TW_W-1:0] addr_next;
  logic [LOG2N-1:0]  out_idx_next;
  logic              out_valid_next;

  // State register.
  // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (flush)      state_next = FLUSH;
      FLUSH:   if (drain_done) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = (state != FLUSH);
    busy     = (state != IDLE);
  end

  // While draining, the pipeline steps every cycle with zero samples.
  assign advance    = (in_valid & in_ready) | (state == FLUSH);
  assign drain_done = (state == FLUSH) && (drain == DRAIN_END);

  // NOTE: every flop, including the control outputs, is cleared by reset; no storage is left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p     <= '0;
      f     <= '0;
      drain <= '0;
    end else if (advance) begin
      if (drain_done) begin
        p     <= '0;
        f     <= '0;
        drain <= '0;
      end else begin
        p <= p + LOG2N'(1);
        if (f != F_SAT)       f     <= f + F_W'(1);
        if (state == FLUSH)   drain <= drain + F_W'(1);
      end
    end
  end

  for (genvar s = 0; s < L; s++) begin : g_stage
    fft_stage_ctl #(.STAGE(s)) u_stage_ctl (
      .p       (p),
      .f       (f),
      .bf_en   (bf_next[s]),
      .tw_en   (tw_next[s]),
      .tw_addr (addr_next[s*TW_W +: TW_W])
    );
  end

  assign out_valid_next = (f == F_SAT);
  assign out_idx_next   = p - TL_MOD;

  // Controls reflect the advance of the previous cycle and are zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_en     <= '0;
      tw_en     <= '0;
      tw_addr   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      bf_en     <= advance ? bf_next   : '0;
      tw_en     <= advance ? tw_next   : '0;
      tw_addr   <= advance ? addr_next : '0;
      out_valid <= advance & out_valid_next;
      out_idx   <= advance ? out_idx_next : '0;
      out_last  <= advance & out_valid_next & (out_idx_next == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_fft512_sdf_sequencer.sv
module tb_fft512_sdf_sequencer;

  localparam int NN  = 512;
  localparam int LL  = 9;
  localparam int TOT = 520;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        busy;
  logic [8:0]  bf_en;
  logic [8:0]  tw_en;
  logic [71:0] tw_addr;
  logic        out_valid;
  logic [8:0]  out_idx;
  logic        out_last;

  fft512_sdf_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .busy      (busy),
    .bf_en     (bf_en),
    .tw_en     (tw_en),
    .tw_addr   (tw_addr),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        adv;
    logic [8:0]  bf;
    logic [8:0]  tw;
    logic [71:0] addr;
    logic        ov;
    logic [8:0]  oidx;
    logic        ol;
    logic        bsy;
    logic        rdy;
  } exp_t;

  exp_t sb_q[$];

  int tests_run;
  int tests_failed;

  // Reference model state (0 idle, 1 run, 2 flush).
  int m_state, m_p, m_f, m_drain;
  int d_off[LL];

  function automatic int mod_n(input int x);
    return ((x % NN) + NN) % NN;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_p     = 0;
    m_f     = 0;
    m_drain = 0;
    sb_q.delete();
  endtask

  // Drive one cycle of inputs and push the output expected after the next edge.
  task automatic drive(input logic v, input logic fl);
    exp_t e;
    int   idx, h, old_state;
    bit   adv, vld, hb;
    @(negedge clk);
    in_valid = v;
    flush    = fl;
    old_state = m_state;
    adv = (v && m_state != 2) || (m_state == 2);
    e.adv  = adv;
    e.bf   = '0;
    e.tw   = '0;
    e.addr = '0;
    e.ov   = 1'b0;
    e.oidx = '0;
    e.ol   = 1'b0;
    if (adv) begin
      for (int s = 0; s < LL; s++) begin
        idx = mod_n(m_p - d_off[s]);
        h   = 1 << (LL - 1 - s);
        vld = (m_f >= d_off[s]);
        hb  = ((idx >> (LL - 1 - s)) & 1) == 1;
        e.bf[s] = vld && hb;
        e.tw[s] = vld && !hb && (m_f >= d_off[s] + h);
        e.addr[s*8 +: 8] = 8'((idx % h) << s);
      end
      e.ov   = (m_f >= TOT);
      e.oidx = 9'(mod_n(m_p - TOT));
      e.ol   = e.ov && (mod_n(m_p - TOT) == NN - 1);
    end
    if (m_state == 0 && v)       m_state = 1;
    else if (m_state == 1 && fl) m_state = 2;
    if (adv) begin
      if (old_state == 2 && m_drain == TOT - 1) begin
        m_state = 0; m_p = 0; m_f = 0; m_drain = 0;
      end else begin
        m_p = (m_p + 1) % NN;
        if (m_f < TOT) m_f++;
        if (old_state == 2) m_drain++;
      end
    end
    e.bsy = (m_state != 0);
    e.rdy = (m_state != 2);
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: one comparison per driven cycle, sampled 1 ns after the edge.
  always @(posedge clk) begin
    exp_t e;
    bit   bad;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bad = (bf_en !== e.bf) || (tw_en !== e.tw) || (tw_addr !== e.addr) ||
            (out_valid !== e.ov) || (out_last !== e.ol) ||
            (busy !== e.bsy) || (in_ready !== e.rdy) ||
            ((e.ov || !e.adv) && (out_idx !== e.oidx));
      tests_run++;
      if (bad) begin
        tests_failed++;
        $display("FAIL scoreboard t=%0t got bf=%h tw=%h addr=%h ov=%b idx=%0d last=%b busy=%b rdy=%b exp bf=%h tw=%h addr=%h ov=%b idx=%0d last=%b busy=%b rdy=%b",
                 $time, bf_en, tw_en, tw_addr, out_valid, out_idx, out_last, busy, in_ready,
                 e.bf, e.tw, e.addr, e.ov, e.oidx, e.ol, e.bsy, e.rdy);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || bf_en !== '0 || tw_en !== '0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold got rdy=%b busy=%b bf=%h tw=%h ov=%b exp rdy=1 busy=0 bf=0 tw=0 ov=0",
               in_ready, busy, bf_en, tw_en, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0);
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || bf_en !== '0) begin
      tests_failed++;
      $display("FAIL reset_release got rdy=%b busy=%b ov=%b bf=%h exp rdy=1 busy=0 ov=0 bf=0",
               in_ready, busy, out_valid, bf_en);
    end
  endtask

  task automatic test_full_frame();
    int adv_cnt, first_bf_p, first_ov, first_idx, vcount, lcount, last_idx, p_before;
    adv_cnt = 0; first_bf_p = -1; first_ov = -1; first_idx = -1;
    vcount = 0; lcount = 0; last_idx = -1;
    for (int i = 0; i < 512 + TOT; i++) begin
      p_before = m_p;
      drive(i < 512, i == 511);
      @(posedge clk); #1;
      adv_cnt++;
      if (bf_en[0] && first_bf_p < 0) first_bf_p = p_before;
      if (out_valid) begin
        if (first_ov < 0) begin first_ov = adv_cnt; first_idx = out_idx; end
        vcount++;
      end
      if (out_last) begin lcount++; last_idx = out_idx; end
      if (i == 512 + TOT - 2) begin
        tests_run++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL flush_busy got busy=%b rdy=%b exp busy=1 rdy=0", busy, in_ready);
        end
      end
    end
    tests_run++;
    if (first_bf_p != 256) begin
      tests_failed++; $display("FAIL first_bf0 got P=%0d exp 256", first_bf_p);
    end
    tests_run++;
    if (first_ov != TOT + 1 || first_idx != 0) begin
      tests_failed++; $display("FAIL first_out got adv=%0d idx=%0d exp adv=521 idx=0", first_ov, first_idx);
    end
    tests_run++;
    if (vcount != 512 || lcount != 1 || last_idx != 511) begin
      tests_failed++;
      $display("FAIL frame_out got valid=%0d last=%0d last_idx=%0d exp 512 1 511", vcount, lcount, last_idx);
    end
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL flush_done got busy=%b rdy=%b exp busy=0 rdy=1", busy, in_ready);
    end
  endtask

  task automatic test_twiddle();
    for (int i = 0; i < 558; i++) begin
      drive(1'b1, 1'b0);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bf_en[1] !== 1'b0 || tw_en[1] !== 1'b1 || tw_addr[15:8] !== 8'd88) begin
      tests_failed++;
      $display("FAIL stage1_twiddle got bf=%b tw=%b addr=%0d exp bf=0 tw=1 addr=88",
               bf_en[1], tw_en[1], tw_addr[15:8]);
    end
  endtask

  task automatic test_stall();
    // Continues the stream of test_twiddle: 558 advances so far.
    for (int i = 0; i < 50; i++) drive(1'b1, 1'b0);
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_idx !== 9'd87) begin
      tests_failed++; $display("FAIL pre_stall got ov=%b idx=%0d exp ov=1 idx=87", out_valid, out_idx);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0);
      @(posedge clk); #1;
      tests_run++;
      if (bf_en !== '0 || tw_en !== '0 || out_valid !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d got bf=%h tw=%h ov=%b busy=%b exp 0 0 0 1", i, bf_en, tw_en, out_valid, busy);
      end
    end
    drive(1'b1, 1'b0);
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_idx !== 9'd88) begin
      tests_failed++; $display("FAIL stall_resume got ov=%b idx=%0d exp ov=1 idx=88", out_valid, out_idx);
    end
    // Flush with a same-cycle sample, then drain.
    drive(1'b1, 1'b1);
    for (int i = 0; i < TOT; i++) drive(1'b0, 1'b0);
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL stall_drain got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, first_ov, gaps, l1, l2, lcount, idx_after;
    cyc = 0; first_ov = -1; gaps = 0; l1 = -1; l2 = -1; lcount = 0; idx_after = -1;
    for (int i = 0; i < 1024 + TOT; i++) begin
      drive(1'b1, i == 1023);
      @(posedge clk); #1;
      cyc++;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (first_ov > 0 && !out_valid) gaps++;
      if (cyc == l1 + 1 && l1 > 0) idx_after = out_idx;
      if (out_last) begin
        lcount++;
        if (l1 < 0) l1 = cyc; else l2 = cyc;
      end
    end
    tests_run++;
    if (lcount != 2 || l2 - l1 != 512) begin
      tests_failed++; $display("FAIL b2b_last got pulses=%0d spacing=%0d exp 2 512", lcount, l2 - l1);
    end
    tests_run++;
    if (gaps != 0 || idx_after != 0) begin
      tests_failed++; $display("FAIL b2b_wrap got gaps=%0d idx_after_last=%0d exp 0 0", gaps, idx_after);
    end
  endtask

  task automatic test_reset_in_flush();
    int adv_cnt, first_ov, first_idx;
    for (int i = 0; i < 600; i++) drive(1'b1, i == 599);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (bf_en !== '0 || tw_en !== '0 || tw_addr !== '0 || out_valid !== 1'b0 ||
        out_idx !== '0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_flush got bf=%h tw=%h addr=%h ov=%b idx=%0d last=%b busy=%b rdy=%b exp all 0 rdy=1",
               bf_en, tw_en, tw_addr, out_valid, out_idx, out_last, busy, in_ready);
    end
    in_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL post_reset got busy=%b rdy=%b exp 0 1", busy, in_ready);
    end
    adv_cnt = 0; first_ov = -1; first_idx = -1;
    for (int i = 0; i < 530; i++) begin
      drive(1'b1, 1'b0);
      @(posedge clk); #1;
      adv_cnt++;
      if (out_valid && first_ov < 0) begin first_ov = adv_cnt; first_idx = out_idx; end
    end
    tests_run++;
    if (first_ov != TOT + 1 || first_idx != 0) begin
      tests_failed++; $display("FAIL restart_frame got adv=%0d idx=%0d exp adv=521 idx=0", first_ov, first_idx);
    end
    // Flush with no sample this cycle, then drain back to idle.
    drive(1'b0, 1'b1);
    for (int i = 0; i < TOT; i++) drive(1'b0, 1'b0);
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL restart_drain got busy=%b exp 0", busy);
    end
  endtask

  initial begin
    int d;
    tests_run = 0; tests_failed = 0;
    d = 0;
    for (int s = 0; s < LL; s++) begin
      d_off[s] = d;
      d += (1 << (LL - 1 - s)) + 1;
    end
    test_reset();
    test_full_frame();
    test_twiddle();
    test_stall();
    test_back_to_back();
    test_reset_in_flush();
    repeat (2) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
